// File: rtl/ub_input_setup_if.sv
// Read port of the unified buffer as seen by the input-setup block.
// master = ub_input_setup (issues reads), slave = unified buffer (returns tile bytes).
interface ub_input_setup_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 13
);

  logic                  ub_load_input;
  logic [ADDR_WIDTH-1:0] ub_addr;
  logic [DATA_WIDTH-1:0] ub_data_00;
  logic [DATA_WIDTH-1:0] ub_data_01;
  logic [DATA_WIDTH-1:0] ub_data_10;
  logic [DATA_WIDTH-1:0] ub_data_11;

  modport master (
    output ub_load_input,
    output ub_addr,
    input  ub_data_00,
    input  ub_data_01,
    input  ub_data_10,
    input  ub_data_11
  );

  modport slave (
    input  ub_load_input,
    input  ub_addr,
    output ub_data_00,
    output ub_data_01,
    output ub_data_10,
    output ub_data_11
  );

endinterface

// File: rtl/ub_input_setup.sv
// Fetches 2x2 activation tiles from the unified buffer and feeds them skewed onto the
// two systolic row inputs. Optional read/stream overlap: INPUT_SETUP_PREFETCH_EN.
module ub_input_setup #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned COUNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] tile_count,
  ub_input_setup_if.master       ub,
  output logic [DATA_WIDTH-1:0]  a_in1,
  output logic [DATA_WIDTH-1:0]  a_in2,
  output logic                   a_valid1,
  output logic                   a_valid2,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned TILE_STRIDE = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAPT = 3'd2,
    S0   = 3'd3,
    S1   = 3'd4,
    S2   = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t                 state, state_n;
  logic [ADDR_WIDTH-1:0]  cur_addr, cur_addr_n;
  logic [COUNT_WIDTH-1:0] tiles_left, tiles_left_n;
  logic [DATA_WIDTH-1:0]  t00, t01, t10, t11;
  logic [DATA_WIDTH-1:0]  t00_n, t01_n, t10_n, t11_n;

  logic                   ub_load_q, ub_load_n;
  logic [ADDR_WIDTH-1:0]  ub_addr_q, ub_addr_n;
  logic [DATA_WIDTH-1:0]  a_in1_n, a_in2_n;
  logic                   a_valid1_n, a_valid2_n;
  logic                   busy_n, done_n;

  logic                   more_tiles;
  logic [ADDR_WIDTH-1:0]  next_tile_addr;

  assign more_tiles     = tiles_left > COUNT_WIDTH'(1);
  assign next_tile_addr = ADDR_WIDTH'(cur_addr + ADDR_WIDTH'(TILE_STRIDE));

  // State, working registers and all outputs are flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      tiles_left <= '0;
      t00        <= '0;
      t01        <= '0;
      t10        <= '0;
      t11        <= '0;
      ub_load_q  <= 1'b0;
      ub_addr_q  <= '0;
      a_in1      <= '0;
      a_in2      <= '0;
      a_valid1   <= 1'b0;
      a_valid2   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cur_addr   <= cur_addr_n;
      tiles_left <= tiles_left_n;
      t00        <= t00_n;
      t01        <= t01_n;
      t10        <= t10_n;
      t11        <= t11_n;
      ub_load_q  <= ub_load_n;
      ub_addr_q  <= ub_addr_n;
      a_in1      <= a_in1_n;
      a_in2      <= a_in2_n;
      a_valid1   <= a_valid1_n;
      a_valid2   <= a_valid2_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  assign ub.ub_load_input = ub_load_q;
  assign ub.ub_addr       = ub_addr_q;

  // Next state and working registers.
  always_comb begin
    state_n      = state;
    cur_addr_n   = cur_addr;
    tiles_left_n = tiles_left;
    t00_n        = t00;
    t01_n        = t01;
    t10_n        = t10;
    t11_n        = t11;

    unique case (state)
      IDLE: begin
        if (start) begin
          cur_addr_n   = base_addr;
          tiles_left_n = tile_count;
          state_n      = (tile_count == '0) ? DONE : REQ;
        end
      end
      REQ:  state_n = CAPT;
      CAPT: begin
        t00_n   = ub.ub_data_00;
        t01_n   = ub.ub_data_01;
        t10_n   = ub.ub_data_10;
        t11_n   = ub.ub_data_11;
        state_n = S0;
      end
      S0:   state_n = S1;
      S1:   state_n = S2;
      S2: begin
        if (more_tiles) begin
          tiles_left_n = COUNT_WIDTH'(tiles_left - COUNT_WIDTH'(1));
          cur_addr_n   = next_tile_addr;
`ifdef INPUT_SETUP_PREFETCH_EN
          // Prefetched tile arrives now; t11 has just been consumed, so overwrite is safe.
          t00_n        = ub.ub_data_00;
          t01_n        = ub.ub_data_01;
          t10_n        = ub.ub_data_10;
          t11_n        = ub.ub_data_11;
          state_n      = S0;
`else
          state_n      = REQ;
`endif
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output values for the upcoming state, computed from next-cycle register contents.
  always_comb begin
    ub_load_n  = 1'b0;
    ub_addr_n  = ub_addr_q;
    a_in1_n    = '0;
    a_in2_n    = '0;
    a_valid1_n = 1'b0;
    a_valid2_n = 1'b0;
    done_n     = 1'b0;
    busy_n     = (state_n != IDLE);

    unique case (state_n)
      REQ: begin
        ub_load_n = 1'b1;
        ub_addr_n = cur_addr_n;
      end
      S0: begin
        a_in1_n    = t00_n;
        a_valid1_n = 1'b1;
      end
      S1: begin
        a_in1_n    = t01_n;
        a_in2_n    = t10_n;
        a_valid1_n = 1'b1;
        a_valid2_n = 1'b1;
`ifdef INPUT_SETUP_PREFETCH_EN
        if (tiles_left_n > COUNT_WIDTH'(1)) begin
          ub_load_n = 1'b1;
          ub_addr_n = ADDR_WIDTH'(cur_addr_n + ADDR_WIDTH'(TILE_STRIDE));
        end
`endif
      end
      S2: begin
        a_in2_n    = t11_n;
        a_valid2_n = 1'b1;
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ub_input_setup.sv
// Directed self-checking bench for ub_input_setup with a behavioural unified-buffer read model.
module tb_ub_input_setup;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 13;
  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] tile_count;
  logic [DW-1:0] a_in1, a_in2;
  logic          a_valid1, a_valid2, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  ub_input_setup_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ub ();

  ub_input_setup #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .tile_count (tile_count),
    .ub         (ub.master),
    .a_in1      (a_in1),
    .a_in2      (a_in2),
    .a_valid1   (a_valid1),
    .a_valid2   (a_valid2),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Unified buffer: one-cycle registered read of four consecutive bytes.
  always_ff @(posedge clk) begin
    if (ub.ub_load_input) begin
      ub.ub_data_00 <= mem[ub.ub_addr];
      ub.ub_data_01 <= mem[AW'(ub.ub_addr + AW'(1))];
      ub.ub_data_10 <= mem[AW'(ub.ub_addr + AW'(2))];
      ub.ub_data_11 <= mem[AW'(ub.ub_addr + AW'(3))];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle, then compare {busy,done,load,v1,v2,a_in1,a_in2}.
  task automatic step_chk(input string tag, input bit b, input bit d, input bit l,
                          input bit v1, input bit v2, input logic [7:0] a1, input logic [7:0] a2);
    cyc();
    check(tag, 32'({busy, done, ub.ub_load_input, a_valid1, a_valid2, a_in1, a_in2}),
               32'({b, d, l, v1, v2, a1, a2}));
  endtask

  task automatic launch(input logic [AW-1:0] ba, input logic [CW-1:0] tc);
    base_addr  = ba;
    tile_count = tc;
    start      = 1'b1;
    cyc();
    start      = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ub.ub_data_00 = '0;
    ub.ub_data_01 = '0;
    ub.ub_data_10 = '0;
    ub.ub_data_11 = '0;

    // Reset with a coincident start: must stay idle.
    reset = 1'b1; start = 1'b1; base_addr = '0; tile_count = CW'(1);
    cyc(); cyc();
    reset = 1'b0; start = 1'b0;
    step_chk("reset_idle", 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check("reset_addr", 32'(ub.ub_addr), 32'h0);
    step_chk("reset_start_ignored", 0, 0, 0, 0, 0, 8'h00, 8'h00);

    // Single tile at address 8.
    mem[8] = 8'h11; mem[9] = 8'h22; mem[10] = 8'h33; mem[11] = 8'h44;
    launch(AW'(8), CW'(1));
    check("one_req", 32'({busy, ub.ub_load_input, a_valid1, a_valid2}), 32'b1100);
    check("one_req_addr", 32'(ub.ub_addr), 32'd8);
    step_chk("one_capt", 1, 0, 0, 0, 0, 8'h00, 8'h00);
    step_chk("one_s0",   1, 0, 0, 1, 0, 8'h11, 8'h00);
    step_chk("one_s1",   1, 0, 0, 1, 1, 8'h22, 8'h33);
    step_chk("one_s2",   1, 0, 0, 0, 1, 8'h00, 8'h44);
    step_chk("one_done", 1, 1, 0, 0, 0, 8'h00, 8'h00);
    step_chk("one_idle", 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check("one_addr_hold", 32'(ub.ub_addr), 32'd8);

    // Zero tile count: straight to DONE.
    launch(AW'(40), CW'(0));
    check("zero_done", 32'({busy, done, ub.ub_load_input, a_valid1, a_valid2}), 32'b11000);
    step_chk("zero_idle", 0, 0, 0, 0, 0, 8'h00, 8'h00);

`ifndef INPUT_SETUP_PREFETCH_EN
    // Two tiles from address 0, bytes 1..8.
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    launch(AW'(0), CW'(2));
    check("two_req0", 32'({ub.ub_load_input, ub.ub_addr}), 32'({1'b1, 13'h0000}));
    step_chk("two_c2",  1, 0, 0, 0, 0, 8'd0, 8'd0);
    step_chk("two_c3",  1, 0, 0, 1, 0, 8'd1, 8'd0);
    step_chk("two_c4",  1, 0, 0, 1, 1, 8'd2, 8'd3);
    step_chk("two_c5",  1, 0, 0, 0, 1, 8'd0, 8'd4);
    step_chk("two_c6",  1, 0, 1, 0, 0, 8'd0, 8'd0);
    check("two_req1_addr", 32'(ub.ub_addr), 32'd4);
    step_chk("two_c7",  1, 0, 0, 0, 0, 8'd0, 8'd0);
    step_chk("two_c8",  1, 0, 0, 1, 0, 8'd5, 8'd0);
    step_chk("two_c9",  1, 0, 0, 1, 1, 8'd6, 8'd7);
    step_chk("two_c10", 1, 0, 0, 0, 1, 8'd0, 8'd8);
    step_chk("two_c11", 1, 1, 0, 0, 0, 8'd0, 8'd0);
    step_chk("two_c12", 0, 0, 0, 0, 0, 8'd0, 8'd0);

    // Address wrap with an ignored start during S0.
    mem[13'h1FFC] = 8'hA1; mem[13'h1FFD] = 8'hA2; mem[13'h1FFE] = 8'hA3; mem[13'h1FFF] = 8'hA4;
    mem[0] = 8'hB1; mem[1] = 8'hB2; mem[2] = 8'hB3; mem[3] = 8'hB4;
    launch(AW'(13'h1FFC), CW'(2));
    check("wrap_req0_addr", 32'(ub.ub_addr), 32'h1FFC);
    step_chk("wrap_c2", 1, 0, 0, 0, 0, 8'h00, 8'h00);
    step_chk("wrap_c3", 1, 0, 0, 1, 0, 8'hA1, 8'h00);
    base_addr = AW'(13'h0100); tile_count = CW'(5); start = 1'b1;
    step_chk("wrap_c4", 1, 0, 0, 1, 1, 8'hA2, 8'hA3);
    start = 1'b0;
    step_chk("wrap_c5", 1, 0, 0, 0, 1, 8'h00, 8'hA4);
    step_chk("wrap_c6", 1, 0, 1, 0, 0, 8'h00, 8'h00);
    check("wrap_req1_addr", 32'(ub.ub_addr), 32'h0000);
    step_chk("wrap_c7",  1, 0, 0, 0, 0, 8'h00, 8'h00);
    step_chk("wrap_c8",  1, 0, 0, 1, 0, 8'hB1, 8'h00);
    step_chk("wrap_c9",  1, 0, 0, 1, 1, 8'hB2, 8'hB3);
    step_chk("wrap_c10", 1, 0, 0, 0, 1, 8'h00, 8'hB4);
    step_chk("wrap_c11", 1, 1, 0, 0, 0, 8'h00, 8'h00);
    step_chk("wrap_c12", 0, 0, 0, 0, 0, 8'h00, 8'h00);
`else
    // Three tiles with overlapped reads; valids contiguous for 9 cycles.
    for (int i = 0; i < 12; i++) mem[32 + i] = 8'(8'h50 + i);
    launch(AW'(32), CW'(3));
    check("pf_req0_addr", 32'({ub.ub_load_input, ub.ub_addr}), 32'({1'b1, 13'd32}));
    step_chk("pf_c2",  1, 0, 0, 0, 0, 8'h00, 8'h00);
    step_chk("pf_c3",  1, 0, 0, 1, 0, 8'h50, 8'h00);
    step_chk("pf_c4",  1, 0, 1, 1, 1, 8'h51, 8'h52);
    check("pf_req1_addr", 32'(ub.ub_addr), 32'd36);
    step_chk("pf_c5",  1, 0, 0, 0, 1, 8'h00, 8'h53);
    step_chk("pf_c6",  1, 0, 0, 1, 0, 8'h54, 8'h00);
    step_chk("pf_c7",  1, 0, 1, 1, 1, 8'h55, 8'h56);
    check("pf_req2_addr", 32'(ub.ub_addr), 32'd40);
    step_chk("pf_c8",  1, 0, 0, 0, 1, 8'h00, 8'h57);
    step_chk("pf_c9",  1, 0, 0, 1, 0, 8'h58, 8'h00);
    step_chk("pf_c10", 1, 0, 0, 1, 1, 8'h59, 8'h5A);
    step_chk("pf_c11", 1, 0, 0, 0, 1, 8'h00, 8'h5B);
    step_chk("pf_c12", 1, 1, 0, 0, 0, 8'h00, 8'h00);
    step_chk("pf_c13", 0, 0, 0, 0, 0, 8'h00, 8'h00);
`endif

    // Reset in S1 abandons the run; done never pulses afterwards.
    launch(AW'(8), CW'(2));
    cyc(); cyc(); cyc();
    check("rst_in_s1", 32'({a_valid1, a_valid2, busy}), 32'b111);
    reset = 1'b1;
    step_chk("rst_mid_run", 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check("rst_mid_addr", 32'(ub.ub_addr), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step_chk($sformatf("rst_quiet_%0d", i), 0, 0, 0, 0, 0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
